// File: rtl/fifo_ctrl_if.sv
// Request/response and RAM-side bundle between fifo_ctrl and its environment.
// The slave modport is the controller; the master modport is producer, consumer and RAM together.
interface fifo_ctrl_if #(
    parameter int LINE_SIZE    = 12,
    parameter int ADDRESS_SIZE = 3
);
    logic                    push;
    logic                    pop;
    logic [LINE_SIZE-1:0]    data_in;
    logic [ADDRESS_SIZE:0]   af_thresh;
    logic [ADDRESS_SIZE:0]   ae_thresh;
    logic [LINE_SIZE-1:0]    q_r;

    logic                    wr_e;
    logic                    rd_e;
    logic [ADDRESS_SIZE-1:0] wr_ptr;
    logic [ADDRESS_SIZE-1:0] rd_ptr;
    logic [LINE_SIZE-1:0]    data_w;
    logic [LINE_SIZE-1:0]    data_out;
    logic                    valid_out;
    logic [ADDRESS_SIZE:0]   count;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    overflow_err;
    logic                    underflow_err;

    modport master (
        output push, pop, data_in, af_thresh, ae_thresh, q_r,
        input  wr_e, rd_e, wr_ptr, rd_ptr, data_w, data_out, valid_out, count,
               full, empty, almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  push, pop, data_in, af_thresh, ae_thresh, q_r,
        output wr_e, rd_e, wr_ptr, rd_ptr, data_w, data_out, valid_out, count,
               full, empty, almost_full, almost_empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Circular-FIFO controller in front of a single-clock dual-port RAM with registered read.
// Owns pointers, occupancy, read-valid strobe and sticky error flags.
module fifo_ctrl #(
    parameter int LINE_SIZE    = 12,
    parameter int ADDRESS_SIZE = 3
) (
    input logic       clk,
    input logic       reset,
    fifo_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0]   COUNT_FULL = (ADDRESS_SIZE + 1)'(DEPTH);
    localparam logic [ADDRESS_SIZE:0]   COUNT_ONE  = (ADDRESS_SIZE + 1)'(1);
    localparam logic [ADDRESS_SIZE-1:0] PTR_ONE    = ADDRESS_SIZE'(1);

    logic [ADDRESS_SIZE-1:0] wr_ptr_q;
    logic [ADDRESS_SIZE-1:0] rd_ptr_q;
    logic [ADDRESS_SIZE:0]   count_q;
    logic                    valid_q;
    logic                    overflow_q;
    logic                    underflow_q;

    logic full;
    logic empty;
    logic wr_e;
    logic rd_e;

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_FULL);

    // Gating on full/empty guarantees a read and write never share an address in one cycle.
    assign wr_e = bus.push & ~full;
    assign rd_e = bus.pop  & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_e) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_e) rd_ptr_q <= rd_ptr_q + PTR_ONE;

            case ({wr_e, rd_e})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase

            // RAM registers its read port, so data lands one cycle after rd_e.
            valid_q <= rd_e;

            if (bus.push && full)  overflow_q  <= 1'b1;
            if (bus.pop  && empty) underflow_q <= 1'b1;
        end
    end

    assign bus.wr_e          = wr_e;
    assign bus.rd_e          = rd_e;
    assign bus.wr_ptr        = wr_ptr_q;
    assign bus.rd_ptr        = rd_ptr_q;
    assign bus.data_w        = bus.data_in;
    assign bus.data_out      = bus.q_r;
    assign bus.valid_out     = valid_q;
    assign bus.count         = count_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.almost_full   = (count_q >= bus.af_thresh);
    assign bus.almost_empty  = (count_q <= bus.ae_thresh);
    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural registered-read RAM model.
module tb_fifo_ctrl;
    localparam int LS = 12;
    localparam int AS = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.LINE_SIZE(LS), .ADDRESS_SIZE(AS)) bus ();

    fifo_ctrl #(.LINE_SIZE(LS), .ADDRESS_SIZE(AS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [LS-1:0] mem [8];
    always @(posedge clk) begin
        if (bus.wr_e) mem[bus.wr_ptr] <= bus.data_w;
        if (bus.rd_e) bus.q_r <= mem[bus.rd_ptr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic q, input logic [LS-1:0] d);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
    endtask

    logic [AS-1:0] exp_ptr;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        bus.af_thresh = 4'd6;
        bus.ae_thresh = 4'd2;
        #12;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        check("rst_ovf", 32'(bus.overflow_err), 32'd0);
        check("rst_udf", 32'(bus.underflow_err), 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: async reset mid-cycle with count 5 and a read in flight
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, LS'(12'h050 + i));
            tick();
        end
        drive(1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        check("t1_pre_count", 32'(bus.count), 32'd5);
        check("t1_pre_valid", 32'(bus.valid_out), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t1_count", 32'(bus.count), 32'd0);
        check("t1_empty", 32'(bus.empty), 32'd1);
        check("t1_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        check("t1_rd_ptr", 32'(bus.rd_ptr), 32'd0);
        check("t1_valid", 32'(bus.valid_out), 32'd0);
        reset = 1'b0;
        tick();

        // Test 2: fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, LS'(i));
            tick();
            check("t2_count", 32'(bus.count), 32'(i));
            check("t2_almost_full", 32'(bus.almost_full), 32'(i >= 6));
            check("t2_almost_empty", 32'(bus.almost_empty), 32'(i <= 2));
            check("t2_full", 32'(bus.full), 32'(i == 8));
        end
        drive(1'b1, 1'b0, 12'h009);
        #1;
        check("t2_wr_e_full", 32'(bus.wr_e), 32'd0);
        check("t2_data_w", 32'(bus.data_w), 32'h009);
        tick();
        check("t2_count_hold", 32'(bus.count), 32'd8);
        check("t2_ovf", 32'(bus.overflow_err), 32'd1);
        check("t2_wr_ptr", 32'(bus.wr_ptr), 32'd0);

        // Test 3: drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, '0);
            tick();
            check("t3_valid", 32'(bus.valid_out), 32'd1);
            check("t3_data", 32'(bus.data_out), 32'(i));
            check("t3_count", 32'(bus.count), 32'(8 - i));
        end
        check("t3_empty", 32'(bus.empty), 32'd1);
        drive(1'b0, 1'b1, '0);
        #1;
        check("t3_rd_e_empty", 32'(bus.rd_e), 32'd0);
        tick();
        check("t3_udf", 32'(bus.underflow_err), 32'd1);
        check("t3_valid_after", 32'(bus.valid_out), 32'd0);
        check("t3_count_hold", 32'(bus.count), 32'd0);
        drive(1'b0, 1'b0, '0);

        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        check("rst2_udf", 32'(bus.underflow_err), 32'd0);

        // Test 4: simultaneous push/pop at count 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, LS'(12'h0A1 + i));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, LS'(12'h0A4 + i));
            tick();
            check("t4_count", 32'(bus.count), 32'd3);
            check("t4_valid", 32'(bus.valid_out), 32'd1);
            check("t4_data", 32'(bus.data_out), 32'h0A1 + 32'(i));
        end
        check("t4_wr_ptr", 32'(bus.wr_ptr), 32'd7);
        check("t4_rd_ptr", 32'(bus.rd_ptr), 32'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, '0);
            tick();
            check("t4_drain", 32'(bus.data_out), 32'h0A5 + 32'(i));
        end
        drive(1'b0, 1'b0, '0);
        check("t4_empty", 32'(bus.empty), 32'd1);

        // Test 5: 20 interleaved push/pop through pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, LS'(12'h100 + i));
            tick();
            exp_ptr = AS'(7 + i + 1);
            check("t5_wr_ptr", 32'(bus.wr_ptr), 32'(exp_ptr));
            drive(1'b0, 1'b1, '0);
            tick();
            check("t5_valid", 32'(bus.valid_out), 32'd1);
            check("t5_data", 32'(bus.data_out), 32'h100 + 32'(i));
            check("t5_rd_ptr", 32'(bus.rd_ptr), 32'(exp_ptr));
        end
        drive(1'b0, 1'b0, '0);
        check("t5_ovf", 32'(bus.overflow_err), 32'd0);
        check("t5_udf", 32'(bus.underflow_err), 32'd0);
        check("t5_wr_ptr_end", 32'(bus.wr_ptr), 32'd3);
        check("t5_count", 32'(bus.count), 32'd0);

        // Test 6: push & pop together on an empty FIFO
        drive(1'b1, 1'b1, 12'h3C3);
        #1;
        check("t6_wr_e", 32'(bus.wr_e), 32'd1);
        check("t6_rd_e", 32'(bus.rd_e), 32'd0);
        tick();
        drive(1'b0, 1'b0, '0);
        check("t6_count", 32'(bus.count), 32'd1);
        check("t6_valid", 32'(bus.valid_out), 32'd0);
        check("t6_udf", 32'(bus.underflow_err), 32'd1);
        check("t6_ovf", 32'(bus.overflow_err), 32'd0);
        drive(1'b0, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        check("t6_readback", 32'(bus.data_out), 32'h3C3);
        check("t6_readback_valid", 32'(bus.valid_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
